// File: rtl/mpe_result_packer.sv
// Packs a stream of 32-bit PE results into 16-lane lines and queues them in a
// small FIFO for a ready/valid downstream; a line that finds the FIFO full is dropped.
module mpe_result_packer #(
    parameter int LANES = 16,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pe_result,
    input  logic                  pe_vld,
    input  logic                  flush,
    output logic [32*LANES-1:0]   out_data,
    output logic [4:0]            out_cnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  busy
);

    localparam int PTR_W  = $clog2(LANES);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int LINE_W = 32 * LANES;

    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [31:0]       acc_reg [LANES];
    logic [LINE_W-1:0] line_next;
    logic              last_word;
    logic              push;
    logic              pop;
    logic              accept;
    logic [4:0]        push_cnt;

    logic [LINE_W-1:0] mem_data [DEPTH];
    logic [4:0]        mem_cnt  [DEPTH];
    logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]     count_reg, count_next;
    logic              overflow_reg;

    // ---------------- accumulation line ----------------
    always_comb begin
        last_word = pe_vld && (ptr_reg == PTR_W'(LANES - 1));
        push      = last_word || (flush && ((ptr_reg != '0) || pe_vld));
        // Lane 15 plus the incoming word naturally yields 16 in five bits.
        push_cnt  = 5'(ptr_reg) + 5'(pe_vld);
        ptr_next  = ptr_reg;
        if (push) begin
            ptr_next = '0;
        end else if (pe_vld) begin
            ptr_next = ptr_reg + PTR_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            // The pushed line already contains the word arriving this cycle.
            assign line_next[32*gi +: 32] =
                (pe_vld && (ptr_reg == PTR_W'(gi))) ? pe_result : acc_reg[gi];

            always_ff @(posedge clk) begin
                if (rst || push) begin
                    acc_reg[gi] <= '0;
                end else if (pe_vld && (ptr_reg == PTR_W'(gi))) begin
                    acc_reg[gi] <= pe_result;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // ---------------- output line FIFO ----------------
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        pop        = out_valid && out_ready;
        accept     = push && ((count_reg != CW'(DEPTH)) || pop);
        count_next = count_reg + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr_reg] <= line_next;
            mem_cnt[wr_ptr_reg]  <= push_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
            if (push && !accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Outputs read as zero whenever nothing is queued, including after reset.
    always_comb begin
        out_valid = (count_reg != '0);
        out_data  = out_valid ? mem_data[rd_ptr_reg] : '0;
        out_cnt   = out_valid ? mem_cnt[rd_ptr_reg]  : '0;
        overflow  = overflow_reg;
        busy      = (ptr_reg != '0) || out_valid;
    end

endmodule
